// File: rtl/mips_store_pkg.sv
// Shared types and constants for the MIPS store unit.
// The MIPS_STORE_RMW_EN build macro selects read-modify-write stores; see mips_store_unit.
package mips_store_pkg;

    typedef enum logic [1:0] {
        OP_SB  = 2'b00,
        OP_SH  = 2'b01,
        OP_SW  = 2'b10,
        OP_ILL = 2'b11
    } store_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10
    } state_t;

    localparam logic [3:0] BE_ALL  = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/mips_store_lane_aligner.sv
// Combinational byte-lane aligner: replicates store data across lanes,
// produces little-endian byte enables and flags misaligned/illegal requests.
module mips_store_lane_aligner
    import mips_store_pkg::*;
(
    input  store_op_t   op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [31:0] writedata_o,
    output logic [3:0]  byteenable_o,
    output logic        misaligned_o
);

    // Lane placement and alignment check per store width
    always_comb begin
        writedata_o  = '0;
        byteenable_o = BE_NONE;
        misaligned_o = 1'b0;
        case (op_i)
            OP_SB: begin
                writedata_o  = {4{data_i[7:0]}};
                byteenable_o = 4'b0001 << addr_lo_i;
            end
            OP_SH: begin
                writedata_o  = {2{data_i[15:0]}};
                byteenable_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_lo_i[0];
            end
            OP_SW: begin
                writedata_o  = data_i;
                byteenable_o = BE_ALL;
                misaligned_o = |addr_lo_i;
            end
            default: begin
                misaligned_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_store_unit.sv
// Memory-write side of the multicycle MIPS datapath: accepts one SB/SH/SW
// request and drives a registered Avalon-style write, holding it under
// waitrequest. Build macro MIPS_STORE_RMW_EN turns SB/SH into a
// read-modify-write of the whole word for memories without byte enables.
module mips_store_unit
    import mips_store_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              done,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic              mem_read,
    output logic [31:0]       mem_writedata,
    output logic [3:0]        mem_byteenable,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              write_q, write_d;
    logic              done_q, done_d;
    logic              mis_q, mis_d;

    logic [31:0]       al_wdata;
    logic [3:0]        al_be;
    logic              al_mis;
    store_op_t         op;

    assign op = store_op_t'(req_op);

    mips_store_lane_aligner u_aligner (
        .op_i         (op),
        .addr_lo_i    (req_addr[1:0]),
        .data_i       (req_data),
        .writedata_o  (al_wdata),
        .byteenable_o (al_be),
        .misaligned_o (al_mis)
    );

`ifdef MIPS_STORE_RMW_EN
    logic        read_q, read_d;
    logic [31:0] lane_mask;

    // Expand the registered byte enables into a bit mask for the merge
    always_comb begin
        lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    end

    assign mem_read = read_q;
`else
    logic unused_readdata;

    assign unused_readdata = ^mem_readdata;
    assign mem_read        = 1'b0;
`endif

    // State and bus register update; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= BE_NONE;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
`ifdef MIPS_STORE_RMW_EN
            read_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            write_q <= write_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
`ifdef MIPS_STORE_RMW_EN
            read_q  <= read_d;
`endif
        end
    end

    // Next-state and next bus values; strobes change only on completion
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        write_d = write_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
`ifdef MIPS_STORE_RMW_EN
        read_d  = read_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (al_mis) begin
                        mis_d = 1'b1;
                    end else begin
                        addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = al_wdata;
                        be_d    = al_be;
`ifdef MIPS_STORE_RMW_EN
                        if (op != OP_SW) begin
                            state_d = S_READ;
                            read_d  = 1'b1;
                        end else begin
                            state_d = S_WRITE;
                            write_d = 1'b1;
                        end
`else
                        state_d = S_WRITE;
                        write_d = 1'b1;
`endif
                    end
                end
            end
`ifdef MIPS_STORE_RMW_EN
            S_READ: begin
                if (!mem_waitrequest) begin
                    wdata_d = (mem_readdata & ~lane_mask) | (wdata_q & lane_mask);
                    be_d    = BE_ALL;
                    read_d  = 1'b0;
                    write_d = 1'b1;
                    state_d = S_WRITE;
                end
            end
`endif
            S_WRITE: begin
                if (!mem_waitrequest) begin
                    write_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                write_d = 1'b0;
            end
        endcase
    end

    assign req_ready      = (state_q == S_IDLE);
    assign done           = done_q;
    assign misaligned     = mis_q;
    assign mem_address    = addr_q;
    assign mem_write      = write_q;
    assign mem_writedata  = wdata_q;
    assign mem_byteenable = be_q;

endmodule

// File: tb/tb_mips_store_unit.sv
// Directed self-checking bench for mips_store_unit.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mips_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        done;
    logic        misaligned;
    logic [31:0] mem_address;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    mips_store_unit #(.ADDR_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .done            (done),
        .misaligned      (misaligned),
        .mem_address     (mem_address),
        .mem_write       (mem_write),
        .mem_read        (mem_read),
        .mem_writedata   (mem_writedata),
        .mem_byteenable  (mem_byteenable),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
    endtask

    task automatic check_bus(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        check({tag, "_write"}, mem_write, 1);
        check({tag, "_read"},  mem_read, 0);
        check({tag, "_addr"},  mem_address, a);
        check({tag, "_wdata"}, mem_writedata, d);
        check({tag, "_be"},    mem_byteenable, be);
        check({tag, "_done"},  done, 0);
        check({tag, "_ready"}, req_ready, 0);
    endtask

    logic [1:0]  mis_op   [3];
    logic [31:0] mis_addr [3];

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
        mem_readdata = '0; mem_waitrequest = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_ready", req_ready, 1);
        check("rst_write", mem_write, 0);
        check("rst_read",  mem_read, 0);
        check("rst_done",  done, 0);
        check("rst_mis",   misaligned, 0);
        check("rst_addr",  mem_address, 0);
        check("rst_be",    mem_byteenable, 0);
        check("rst_wdata", mem_writedata, 0);

        // SB, no wait
        request(2'b00, 32'h0000_1003, 32'h0000_00AB);
        tick();
        req_valid = 1'b0;
        check_bus("sb", 32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
        tick();
        check("sb_done",   done, 1);
        check("sb_wr_off", mem_write, 0);
        check("sb_ready",  req_ready, 1);
        tick();
        check("sb_done_pulse", done, 0);

        // SH with three wait states
        mem_waitrequest = 1'b1;
        request(2'b01, 32'h0000_2002, 32'h0000_BEEF);
        tick();
        req_valid = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            check_bus("sh_wait", 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
            tick();
        end
        mem_waitrequest = 1'b0;
        check_bus("sh_last", 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
        tick();
        check("sh_done",   done, 1);
        check("sh_wr_off", mem_write, 0);
        tick();
        check("sh_done_pulse", done, 0);

        // Misaligned and illegal requests
        mis_op[0] = 2'b10; mis_addr[0] = 32'h0000_3001;
        mis_op[1] = 2'b01; mis_addr[1] = 32'h0000_3003;
        mis_op[2] = 2'b11; mis_addr[2] = 32'h0000_3000;
        for (int unsigned i = 0; i < 3; i++) begin
            request(mis_op[i], mis_addr[i], 32'h1234_5678);
            tick();
            req_valid = 1'b0;
            check("mis_flag",  misaligned, 1);
            check("mis_write", mem_write, 0);
            check("mis_done",  done, 0);
            check("mis_ready", req_ready, 1);
            tick();
            check("mis_pulse", misaligned, 0);
            check("mis_write2", mem_write, 0);
            check("mis_done2",  done, 0);
        end

        // Reset while stalled in WRITE
        mem_waitrequest = 1'b1;
        request(2'b10, 32'h0000_5000, 32'h0000_0001);
        tick();
        req_valid = 1'b0;
        check("rw_write", mem_write, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_waitrequest = 1'b0;
        check("rw_write_off", mem_write, 0);
        check("rw_ready",     req_ready, 1);
        check("rw_done",      done, 0);
        tick();
        check("rw_done2",     done, 0);
        request(2'b10, 32'h0000_4000, 32'hDEAD_BEEF);
        tick();
        req_valid = 1'b0;
        check_bus("sw_after_rst", 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111);
        tick();
        check("sw_after_rst_done", done, 1);
        tick();

        // Back-to-back with req_valid held high
        request(2'b10, 32'h0000_0010, 32'h1234_5678);
        tick();
        request(2'b00, 32'h0000_0015, 32'h0000_007F);
        check_bus("b2b_sw", 32'h0000_0010, 32'h1234_5678, 4'b1111);
        tick();
        check("b2b_done1",  done, 1);
        check("b2b_ready1", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check_bus("b2b_sb", 32'h0000_0014, 32'h7F7F_7F7F, 4'b0010);
        tick();
        check("b2b_done2", done, 1);
        tick();
        check("b2b_idle", done, 0);

`ifdef MIPS_STORE_RMW_EN
        // Read-modify-write byte store
        mem_readdata = 32'h1122_3344;
        request(2'b00, 32'h0000_1001, 32'h0000_0055);
        tick();
        req_valid = 1'b0;
        check("rmw_read",  mem_read, 1);
        check("rmw_nowr",  mem_write, 0);
        check("rmw_raddr", mem_address, 32'h0000_1000);
        tick();
        check("rmw_read_off", mem_read, 0);
        check("rmw_write",    mem_write, 1);
        check("rmw_wdata",    mem_writedata, 32'h1122_5544);
        check("rmw_be",       mem_byteenable, 4'b1111);
        check("rmw_nodone",   done, 0);
        tick();
        check("rmw_done", done, 1);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
